// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter and other clients of the shared adder.
package adder_arbiter_pkg;

   localparam int ADDER_BUS_WIDTH       = 32;
   localparam int ADDER_CLA_BLOCK_WIDTH = 4;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the clients and the adder arbiter.
interface adder_arbiter_if
   import adder_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int BUS_WIDTH = ADDER_BUS_WIDTH
) ();

   localparam int ID_W = id_w(NUM_REQ);

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ*BUS_WIDTH-1:0] req_in1;
   logic [NUM_REQ*BUS_WIDTH-1:0] req_in2;
   logic                         rsp_valid;
   logic                         rsp_ready;
   logic [ID_W-1:0]              rsp_id;
   logic [BUS_WIDTH-1:0]         rsp_sum;

   // Client side: offers operands, consumes results.
   modport master (
      output req_valid, req_in1, req_in2, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_in1, req_in2, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum
   );

endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward with wrap, grants the first requester.
module rr_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = id_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         en,
   output logic [N-1:0] gnt,
   output logic [W-1:0] gnt_idx
);

   logic         found;
   logic [W-1:0] idx;

   // Pick the first requester at or after ptr; gnt_idx is valid whenever any req is set.
   always_comb begin
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      gnt     = '0;
      for (int k = 0; k < N; k++) begin
         idx = W'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
      if (en && found) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Block carry-look-ahead adder; BLOCK_WIDTH must divide WIDTH, carry out is dropped.
module carry_look_ahead_adder #(
   parameter int WIDTH       = 32,
   parameter int BLOCK_WIDTH = 4
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] sum
);

   localparam int NUM_BLOCKS = WIDTH / BLOCK_WIDTH;

   // The top bit's generate would only feed the discarded carry out.
   logic [WIDTH-2:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH-1:0] carry;

   assign gen  = in1[WIDTH-2:0] & in2[WIDTH-2:0];
   assign prop = in1 ^ in2;

   // Block carry-ins by look-ahead over block generate/propagate, then ripple inside each block.
   always_comb begin
      logic blk_gen;
      logic blk_prop;
      carry    = '0;
      blk_gen  = 1'b0;
      blk_prop = 1'b0;
      for (int b = 0; b < NUM_BLOCKS - 1; b++) begin
         blk_gen  = 1'b0;
         blk_prop = 1'b1;
         for (int j = 0; j < BLOCK_WIDTH; j++) begin
            blk_gen  = gen[b*BLOCK_WIDTH + j] | (prop[b*BLOCK_WIDTH + j] & blk_gen);
            blk_prop = blk_prop & prop[b*BLOCK_WIDTH + j];
         end
         carry[(b+1)*BLOCK_WIDTH] = blk_gen | (blk_prop & carry[b*BLOCK_WIDTH]);
      end
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         for (int j = 1; j < BLOCK_WIDTH; j++) begin
            carry[b*BLOCK_WIDTH + j] = gen[b*BLOCK_WIDTH + j - 1]
                                     | (prop[b*BLOCK_WIDTH + j - 1] & carry[b*BLOCK_WIDTH + j - 1]);
         end
      end
   end

   assign sum = prop ^ carry;

endmodule

// File: rtl/adder_arbiter.sv
// Shares one CLA adder among NUM_REQ requesters with round-robin grant and a one-entry result slot.
module adder_arbiter
   import adder_arbiter_pkg::*;
#(
   parameter  int NUM_REQ         = 4,
   parameter  int BUS_WIDTH       = ADDER_BUS_WIDTH,
   parameter  int CLA_BLOCK_WIDTH = ADDER_CLA_BLOCK_WIDTH,
   localparam int ID_W            = id_w(NUM_REQ)
) (
   input logic            clk,
   input logic            rst,
   adder_arbiter_if.slave bus
);

   slot_state_e          state_q, state_d;
   logic [BUS_WIDTH-1:0] sum_q, sum_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;

   logic                 can_accept;
   logic                 accept;
   logic [NUM_REQ-1:0]   gnt;
   logic [ID_W-1:0]      gnt_idx;
   logic [BUS_WIDTH-1:0] op1, op2, adder_sum;

   // The slot can take a new result when empty or when the current one leaves this cycle.
   assign can_accept = (state_q == SLOT_EMPTY) || bus.rsp_ready;
   assign accept     = can_accept && (|bus.req_valid);

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (bus.req_valid),
      .ptr     (ptr_q),
      .en      (can_accept),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign op1 = bus.req_in1[int'(gnt_idx)*BUS_WIDTH +: BUS_WIDTH];
   assign op2 = bus.req_in2[int'(gnt_idx)*BUS_WIDTH +: BUS_WIDTH];

   carry_look_ahead_adder #(
      .WIDTH       (BUS_WIDTH),
      .BLOCK_WIDTH (CLA_BLOCK_WIDTH)
   ) u_adder (
      .in1 (op1),
      .in2 (op2),
      .sum (adder_sum)
   );

   // Next slot contents and pointer: capture on accept, drain when consumed without refill.
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      if (accept) begin
         state_d = SLOT_FULL;
         sum_d   = adder_sum;
         id_d    = gnt_idx;
         ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if ((state_q == SLOT_FULL) && bus.rsp_ready) begin
         state_d = SLOT_EMPTY;
      end
   end

   // Slot and pointer registers; reset drops any held result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         sum_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.req_ready = gnt;
   assign bus.rsp_valid = (state_q == SLOT_FULL);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_sum   = sum_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized, self-checking bench for adder_arbiter against a behavioural slot/round-robin model.
module tb_adder_arbiter;
   import adder_arbiter_pkg::*;

   localparam int NREQ = 4;
   localparam int BW   = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   adder_arbiter_if #(.NUM_REQ(NREQ), .BUS_WIDTH(BW)) bus ();

   adder_arbiter #(
      .NUM_REQ         (NREQ),
      .BUS_WIDTH       (BW),
      .CLA_BLOCK_WIDTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;

   // Behavioural model: who is next in the rotation and what the output slot holds.
   int              m_ptr;
   bit              m_full;
   logic [BW-1:0]   m_sum;
   int              m_id;
   logic [BW-1:0]   op_a [NREQ];
   logic [BW-1:0]   op_b [NREQ];

   logic [NREQ-1:0] exp_ready;
   logic [NREQ-1:0] obs_ready;
   bit              exp_acc;
   int              exp_g;
   bit              refill;
   bit              rand_arrivals;

   task automatic model_reset();
      m_ptr  = 0;
      m_full = 1'b0;
      m_sum  = '0;
      m_id   = 0;
   endtask

   task automatic set_req(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b);
      op_a[i] = a;
      op_b[i] = b;
      bus.req_in1[i*BW +: BW] = a;
      bus.req_in2[i*BW +: BW] = b;
      bus.req_valid[i] = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #12;
      rst = 1'b0;
   endtask

   // One clock: predict the grant, sample req_ready, advance the model, then play the requesters.
   task automatic cycle();
      @(negedge clk);
      exp_ready = '0;
      exp_acc   = 1'b0;
      exp_g     = 0;
      if (!m_full || bus.rsp_ready) begin
         for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (!exp_acc && bus.req_valid[i]) begin
               exp_acc = 1'b1;
               exp_g   = i;
            end
         end
      end
      if (exp_acc) exp_ready[exp_g] = 1'b1;
      obs_ready = bus.req_ready;
      @(posedge clk);
      if (exp_acc) begin
         m_full = 1'b1;
         m_sum  = op_a[exp_g] + op_b[exp_g];
         m_id   = exp_g;
         m_ptr  = (exp_g + 1) % NREQ;
      end else if (bus.rsp_ready) begin
         m_full = 1'b0;
      end
      #1;
      if (exp_acc) begin
         if (refill) set_req(exp_g, $urandom, $urandom);
         else        bus.req_valid[exp_g] = 1'b0;
      end
      if (rand_arrivals) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i] && $urandom_range(0, 99) < 40) set_req(i, $urandom, $urandom);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (bus.rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %0b expected 0", bus.rsp_valid);
      else passed++;
      checks++;
      if (bus.rsp_sum !== '0) $display("[TB] FAIL reset_rsp_sum: got %0h expected 0", bus.rsp_sum);
      else passed++;
      checks++;
      if (bus.rsp_id !== '0) $display("[TB] FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id);
      else passed++;
      checks++;
      if (bus.req_ready !== 4'b0000) $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus.req_ready);
      else passed++;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.rsp_ready = 1'b1;
      rand_arrivals = 1'b1;
      repeat (3) cycle();
      rand_arrivals = 1'b0;
      bus.req_valid = '0;
      do_reset();
      set_req(2, 32'd12, 32'd16);
      cycle();
      checks++;
      if (obs_ready !== 4'b0100) $display("[TB] FAIL single_req_ready: got %b expected 0100", obs_ready);
      else passed++;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'd28 || bus.rsp_id !== 2'd2)
         $display("[TB] FAIL single_rsp: got v=%0b sum=%0d id=%0d expected v=1 sum=28 id=2",
                  bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
      else passed++;
      cycle();
      checks++;
      if (obs_ready !== 4'b0000 || bus.rsp_valid !== 1'b0)
         $display("[TB] FAIL single_drain: got ready=%b v=%0b expected ready=0000 v=0", obs_ready, bus.rsp_valid);
      else passed++;
   endtask

   task automatic test_wrap();
      bus.rsp_ready = 1'b1;
      set_req(0, 32'hFFFF_FFFF, 32'h0000_0001);
      cycle();
      checks++;
      if (bus.rsp_sum !== 32'h0 || bus.rsp_id !== 2'd0 || bus.rsp_valid !== 1'b1)
         $display("[TB] FAIL wrap_ones: got sum=%0h id=%0d expected sum=0 id=0", bus.rsp_sum, bus.rsp_id);
      else passed++;
      set_req(1, 32'h8000_0000, 32'h8000_0000);
      cycle();
      checks++;
      if (bus.rsp_sum !== 32'h0 || bus.rsp_id !== 2'd1)
         $display("[TB] FAIL wrap_msb: got sum=%0h id=%0d expected sum=0 id=1", bus.rsp_sum, bus.rsp_id);
      else passed++;
      cycle();
   endtask

   task automatic test_rotation();
      bus.req_valid = '0;
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom);
      bus.rsp_ready = 1'b1;
      refill = 1'b1;
      for (int n = 0; n < 8; n++) begin
         cycle();
         checks++;
         if (obs_ready !== exp_ready || int'(bus.rsp_id) !== (n % NREQ) || bus.rsp_sum !== m_sum)
            $display("[TB] FAIL rotation_%0d: got ready=%b id=%0d sum=%0h expected ready=%b id=%0d sum=%0h",
                     n, obs_ready, bus.rsp_id, bus.rsp_sum, exp_ready, n % NREQ, m_sum);
         else passed++;
      end
      refill = 1'b0;
      bus.req_valid = '0;
   endtask

   task automatic test_backpressure();
      logic [BW-1:0] hold_sum;
      int            hold_id;
      bus.rsp_ready = 1'b0;
      hold_sum = m_sum;
      hold_id  = m_id;
      set_req(1, $urandom, $urandom);
      for (int n = 0; n < 5; n++) begin
         cycle();
         checks++;
         if (obs_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || bus.rsp_sum !== hold_sum
             || int'(bus.rsp_id) !== hold_id)
            $display("[TB] FAIL backpressure_hold_%0d: got ready=%b v=%0b sum=%0h id=%0d expected ready=0000 v=1 sum=%0h id=%0d",
                     n, obs_ready, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, hold_sum, hold_id);
         else passed++;
      end
      bus.rsp_ready = 1'b1;
      cycle();
      checks++;
      if (obs_ready !== 4'b0010 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== m_sum)
         $display("[TB] FAIL backpressure_release: got ready=%b v=%0b id=%0d sum=%0h expected ready=0010 v=1 id=1 sum=%0h",
                  obs_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, m_sum);
      else passed++;
   endtask

   task automatic test_pointer_skip();
      bus.req_valid = '0;
      do_reset();
      bus.rsp_ready = 1'b1;
      set_req(2, $urandom, $urandom);
      cycle();
      checks++;
      if (obs_ready !== 4'b0100) $display("[TB] FAIL skip_first: got %b expected 0100", obs_ready);
      else passed++;
      set_req(0, $urandom, $urandom);
      set_req(1, $urandom, $urandom);
      cycle();
      checks++;
      if (obs_ready !== 4'b0001 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== m_sum)
         $display("[TB] FAIL skip_wrap0: got ready=%b id=%0d sum=%0h expected ready=0001 id=0 sum=%0h",
                  obs_ready, bus.rsp_id, bus.rsp_sum, m_sum);
      else passed++;
      cycle();
      checks++;
      if (obs_ready !== 4'b0010 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== m_sum)
         $display("[TB] FAIL skip_then1: got ready=%b id=%0d sum=%0h expected ready=0010 id=1 sum=%0h",
                  obs_ready, bus.rsp_id, bus.rsp_sum, m_sum);
      else passed++;
   endtask

   task automatic test_reset_mid();
      bus.rsp_ready = 1'b1;
      set_req(0, $urandom, $urandom);
      cycle();
      bus.rsp_ready = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b1) $display("[TB] FAIL midreset_full: got v=%0b expected 1", bus.rsp_valid);
      else passed++;
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.rsp_id !== '0)
         $display("[TB] FAIL midreset_async: got v=%0b sum=%0h id=%0d expected v=0 sum=0 id=0",
                  bus.rsp_valid, bus.rsp_sum, bus.rsp_id);
      else passed++;
      #4 rst = 1'b0;
      bus.req_valid = '0;
      set_req(3, $urandom, $urandom);
      bus.rsp_ready = 1'b1;
      cycle();
      checks++;
      if (obs_ready !== 4'b1000 || bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_sum !== m_sum)
         $display("[TB] FAIL midreset_req3: got ready=%b v=%0b id=%0d sum=%0h expected ready=1000 v=1 id=3 sum=%0h",
                  obs_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, m_sum);
      else passed++;
   endtask

   task automatic test_random();
      rand_arrivals = 1'b1;
      for (int n = 0; n < 300; n++) begin
         bus.rsp_ready = ($urandom_range(0, 99) < 70);
         cycle();
         checks++;
         if (obs_ready !== exp_ready || bus.rsp_valid !== m_full
             || (m_full && (bus.rsp_sum !== m_sum || int'(bus.rsp_id) !== m_id)))
            $display("[TB] FAIL random_%0d: got ready=%b v=%0b sum=%0h id=%0d expected ready=%b v=%0b sum=%0h id=%0d",
                     n, obs_ready, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, exp_ready, m_full, m_sum, m_id);
         else passed++;
      end
      rand_arrivals = 1'b0;
   endtask

   initial begin
      rst           = 1'b0;
      bus.req_valid = '0;
      bus.req_in1   = '0;
      bus.req_in2   = '0;
      bus.rsp_ready = 1'b0;
      refill        = 1'b0;
      rand_arrivals = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      model_reset();
      #1 rst = 1'b1;
      test_reset();
      test_wrap();
      test_rotation();
      test_backpressure();
      test_pointer_skip();
      test_reset_mid();
      test_random();
      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
